// File: rtl/tff_toggle_decoder_pkg.sv
// tff_toggle_decoder_pkg: shared FSM state type and default parameters for the toggle decoder
package tff_toggle_decoder_pkg;
  typedef enum logic [1:0] {EMPTY, AVAIL, FULL} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/tff_sync_chain.sv
// tff_sync_chain: SYNC_STAGES-deep flop chain bringing an unclocked level into clk
// ports: clk, reset (async active-low, clears chain to 0), i_d raw level, o_q synchronized level
module tff_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_q <= '0;
    else        r_q <= {r_q[SYNC_STAGES-2:0], i_d};
  assign o_q = r_q[SYNC_STAGES-1];
endmodule

// File: rtl/tff_toggle_decoder.sv
// tff_toggle_decoder: turns toggle-encoded events back into pulses, buffers them and hands them out over valid/ready
// ports: clk, reset (async active-low), t_in toggle line, clr_ovf clears overflow, evt_ready consumer accept,
//        evt_valid pending>0, evt_pulse one cycle per toggle, pend_cnt/total_cnt counters, overflow sticky drop flag
module tff_toggle_decoder
  import tff_toggle_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_in,
  input  logic             clr_ovf,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] pend_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output logic             overflow
);
  localparam logic [CNT_W-1:0] MAX_PEND = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t           r_state, w_next;
  logic             w_sync, r_prev, w_detect, w_pop, w_inc, w_dec, w_drop;
  logic [CNT_W-1:0] r_pend, r_total;
  logic             r_pulse, r_ovf;
  tff_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (t_in),
    .o_q  (w_sync)
  );
  assign w_detect = w_sync ^ r_prev;
  assign w_pop    = evt_valid & evt_ready;
  // simultaneous detect and pop cancel out; a detect with no room and no pop is dropped
  assign w_inc    = w_detect & ~w_pop & (r_state != FULL);
  assign w_dec    = w_pop & ~w_detect;
  assign w_drop   = w_detect & ~w_pop & (r_state == FULL);
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= EMPTY;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   w_next = w_detect ? ((MAX_PEND == ONE) ? FULL : AVAIL) : EMPTY;
      AVAIL:   w_next = w_inc ? ((r_pend == MAX_PEND - ONE) ? FULL : AVAIL)
                      : w_dec ? ((r_pend == ONE) ? EMPTY : AVAIL) : AVAIL;
      FULL:    w_next = w_dec ? AVAIL : FULL;
      default: w_next = EMPTY;
    endcase
  end
  always_comb begin
    evt_valid = r_state != EMPTY;
    evt_pulse = r_pulse;
    pend_cnt  = r_pend;
    total_cnt = r_total;
    overflow  = r_ovf;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
      r_pend  <= '0;
      r_total <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_prev  <= w_sync;
      r_pulse <= w_detect;
      r_pend  <= w_inc ? r_pend + ONE : w_dec ? r_pend - ONE : r_pend;
      r_total <= r_total + (w_detect ? ONE : '0);
      r_ovf   <= w_drop ? 1'b1 : clr_ovf ? 1'b0 : r_ovf;
    end
endmodule

// File: tb/tb_tff_toggle_decoder.sv
// tb_tff_toggle_decoder: directed bench for tff_toggle_decoder with SYNC_STAGES=2, CNT_W=4
module tb_tff_toggle_decoder;
  logic       clk = 1'b0;
  logic       reset, t_in, clr_ovf, evt_ready;
  logic       evt_valid, evt_pulse, overflow;
  logic [3:0] pend_cnt, total_cnt;
  int         vec = 0;
  int         errs = 0;

  tff_toggle_decoder #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .t_in     (t_in),
    .clr_ovf  (clr_ovf),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_pulse(evt_pulse),
    .pend_cnt (pend_cnt),
    .total_cnt(total_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; t_in = 1'b1; clr_ovf = 1'b0; evt_ready = 1'b0;
    repeat (3) step();
    vec++;
    if ({evt_pulse, evt_valid, overflow, pend_cnt, total_cnt} !== 11'd0) begin
      errs++;
      $display("FAIL reset_outputs got pulse=%b valid=%b ovf=%b pend=%0d total=%0d want all 0",
               evt_pulse, evt_valid, overflow, pend_cnt, total_cnt);
    end
    reset = 1'b1;
    step();
    step();
    vec++;
    if (evt_pulse !== 1'b0) begin errs++; $display("FAIL reset_early_pulse got %b want 0", evt_pulse); end
    step();
    vec++;
    if ({evt_pulse, evt_valid, pend_cnt, total_cnt} !== {1'b1, 1'b1, 4'd1, 4'd1}) begin
      errs++;
      $display("FAIL reset_release_event got pulse=%b valid=%b pend=%0d total=%0d want 1 1 1 1",
               evt_pulse, evt_valid, pend_cnt, total_cnt);
    end
    step();
    vec++;
    if ({evt_pulse, pend_cnt} !== {1'b0, 4'd1}) begin
      errs++;
      $display("FAIL reset_single_pulse got pulse=%b pend=%0d want 0 1", evt_pulse, pend_cnt);
    end
    evt_ready = 1'b1;
    step();
    vec++;
    if ({evt_valid, pend_cnt} !== {1'b0, 4'd0}) begin
      errs++;
      $display("FAIL reset_pop got valid=%b pend=%0d want 0 0", evt_valid, pend_cnt);
    end
    step();
    vec++;
    if ({evt_valid, pend_cnt} !== {1'b0, 4'd0}) begin
      errs++;
      $display("FAIL ready_when_empty got valid=%b pend=%0d want 0 0", evt_valid, pend_cnt);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_single();
    t_in = 1'b0;
    step();
    step();
    vec++;
    if (evt_pulse !== 1'b0) begin errs++; $display("FAIL single_early got %b want 0", evt_pulse); end
    step();
    vec++;
    if ({evt_pulse, evt_valid, pend_cnt, total_cnt} !== {1'b1, 1'b1, 4'd1, 4'd2}) begin
      errs++;
      $display("FAIL single_event got pulse=%b valid=%b pend=%0d total=%0d want 1 1 1 2",
               evt_pulse, evt_valid, pend_cnt, total_cnt);
    end
    t_in = 1'b1;
    step();
    step();
    evt_ready = 1'b1;
    step();
    vec++;
    if ({evt_pulse, pend_cnt, total_cnt} !== {1'b1, 4'd1, 4'd3}) begin
      errs++;
      $display("FAIL avail_pop_detect got pulse=%b pend=%0d total=%0d want 1 1 3", evt_pulse, pend_cnt, total_cnt);
    end
    step();
    vec++;
    if ({evt_valid, pend_cnt} !== {1'b0, 4'd0}) begin
      errs++;
      $display("FAIL single_pop got valid=%b pend=%0d want 0 0", evt_valid, pend_cnt);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_burst();
    for (int k = 0; k < 8; k++) begin
      if (k < 5) t_in = ~t_in;
      step();
      vec++;
      if (evt_pulse !== (k >= 2 && k <= 6)) begin
        errs++;
        $display("FAIL burst_pulse_%0d got %b want %b", k, evt_pulse, (k >= 2 && k <= 6));
      end
    end
    vec++;
    if ({pend_cnt, total_cnt} !== {4'd5, 4'd8}) begin
      errs++;
      $display("FAIL burst_counts got pend=%0d total=%0d want 5 8", pend_cnt, total_cnt);
    end
    evt_ready = 1'b1;
    repeat (5) step();
    evt_ready = 1'b0;
    vec++;
    if ({evt_valid, pend_cnt} !== {1'b0, 4'd0}) begin
      errs++;
      $display("FAIL burst_drain got valid=%b pend=%0d want 0 0", evt_valid, pend_cnt);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 18; k++) begin
      if (k < 16) t_in = ~t_in;
      step();
      if (k == 16) begin
        vec++;
        if ({pend_cnt, overflow} !== {4'd15, 1'b0}) begin
          errs++;
          $display("FAIL fill_no_ovf got pend=%0d ovf=%b want 15 0", pend_cnt, overflow);
        end
      end
    end
    vec++;
    if ({pend_cnt, overflow, total_cnt} !== {4'd15, 1'b1, 4'd8}) begin
      errs++;
      $display("FAIL overflow_drop got pend=%0d ovf=%b total=%0d want 15 1 8", pend_cnt, overflow, total_cnt);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    vec++;
    if (overflow !== 1'b0) begin errs++; $display("FAIL clr_ovf got %b want 0", overflow); end
    t_in = ~t_in;
    step();
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    vec++;
    if ({overflow, evt_pulse, pend_cnt, total_cnt} !== {1'b1, 1'b1, 4'd15, 4'd9}) begin
      errs++;
      $display("FAIL set_beats_clear got ovf=%b pulse=%b pend=%0d total=%0d want 1 1 15 9",
               overflow, evt_pulse, pend_cnt, total_cnt);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
  endtask

  task automatic test_full_pop_detect();
    t_in = ~t_in;
    step();
    step();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    vec++;
    if ({pend_cnt, overflow, total_cnt, evt_pulse} !== {4'd15, 1'b0, 4'd10, 1'b1}) begin
      errs++;
      $display("FAIL full_pop_detect got pend=%0d ovf=%b total=%0d pulse=%b want 15 0 10 1",
               pend_cnt, overflow, total_cnt, evt_pulse);
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    vec++;
    if (pend_cnt !== 4'd14) begin errs++; $display("FAIL full_pop got pend=%0d want 14", pend_cnt); end
    t_in = ~t_in;
    repeat (3) step();
    vec++;
    if ({pend_cnt, overflow, total_cnt} !== {4'd15, 1'b0, 4'd11}) begin
      errs++;
      $display("FAIL refill got pend=%0d ovf=%b total=%0d want 15 0 11", pend_cnt, overflow, total_cnt);
    end
    evt_ready = 1'b1;
    repeat (12) step();
    evt_ready = 1'b0;
    vec++;
    if ({evt_valid, pend_cnt} !== {1'b1, 4'd3}) begin
      errs++;
      $display("FAIL drain_to_3 got valid=%b pend=%0d want 1 3", evt_valid, pend_cnt);
    end
  endtask

  task automatic test_mid_reset();
    #2;
    reset = 1'b0;
    #1;
    vec++;
    if ({evt_valid, pend_cnt, total_cnt, overflow} !== {1'b0, 4'd0, 4'd0, 1'b0}) begin
      errs++;
      $display("FAIL async_reset got valid=%b pend=%0d total=%0d ovf=%b want 0 0 0 0",
               evt_valid, pend_cnt, total_cnt, overflow);
    end
    t_in = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      vec++;
      if ({evt_pulse, pend_cnt} !== {1'b0, 4'd0}) begin
        errs++;
        $display("FAIL post_reset_quiet_%0d got pulse=%b pend=%0d want 0 0", k, evt_pulse, pend_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop_detect();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
